// File: rtl/dvp_capture_ctrl.sv
// Frame-capture sequencer: forwards whole DVP frames from the receiver stream to a video sink.
// Checks line/frame geometry and reports beats lost when the sink stalls.
module dvp_capture_ctrl #(
    parameter int H_BYTES = 1280,
    parameter int V_LINES = 480,
    parameter int CNT_W   = 16
) (
    input  logic             pclk,
    input  logic             aresetn,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    input  logic             abort,
    input  logic             clear_err,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             err_overflow,
    output logic             err_geometry
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_mode;
    logic             r_stop_req;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_frame_done;
    logic             r_err_ovf;
    logic             r_err_geo;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_out_user;

    logic             w_out_free;
    logic             w_stop_eff;
    logic [CNT_W-1:0] w_base_byte;
    logic [CNT_W-1:0] w_base_line;
    logic [CNT_W-1:0] w_byte_inc;
    logic [CNT_W-1:0] w_line_inc;
    logic             w_line_bad;
    logic             w_frame_last;
    logic             w_fwd;
    logic             w_ovf;
    logic             w_geo;
    logic             w_frame_end;
    state_t           w_end_target;

    // A start-of-frame beat restarts the geometry counters before it is counted itself.
    assign w_out_free   = !r_out_valid || m_axis_tready;
    assign w_stop_eff   = r_stop_req || stop;
    assign w_base_byte  = s_axis_tuser ? '0 : r_byte_cnt;
    assign w_base_line  = s_axis_tuser ? '0 : r_line_cnt;
    assign w_byte_inc   = (w_base_byte == '1) ? w_base_byte : w_base_byte + CNT_W'(1);
    assign w_line_inc   = w_base_line + CNT_W'(1);
    assign w_line_bad   = s_axis_tlast && (w_byte_inc != CNT_W'(H_BYTES));
    assign w_frame_last = s_axis_tlast && (w_line_inc == CNT_W'(V_LINES));
    assign w_end_target = (r_mode && !w_stop_eff) ? ST_WAIT_SOF : ST_IDLE;

    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_next_state = ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    if (r_stop_req)       w_next_state = ST_IDLE;
                    else if (w_fwd)       w_next_state = w_frame_end ? w_end_target : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_ovf)            w_next_state = ST_WAIT_SOF;
                    else if (w_frame_end) w_next_state = w_end_target;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_fwd       = 1'b0;
        w_ovf       = 1'b0;
        w_geo       = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_WAIT_SOF: begin
                if (!abort && !r_stop_req && s_axis_tvalid && s_axis_tuser) begin
                    if (w_out_free) begin
                        w_fwd       = 1'b1;
                        w_geo       = w_line_bad;
                        w_frame_end = w_frame_last;
                    end else begin
                        w_ovf = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (!abort && s_axis_tvalid) begin
                    if (w_out_free) begin
                        w_fwd       = 1'b1;
                        w_geo       = s_axis_tuser || w_line_bad;
                        w_frame_end = w_frame_last;
                    end else begin
                        w_ovf = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mode        <= 1'b0;
            r_stop_req    <= 1'b0;
            r_byte_cnt    <= '0;
            r_line_cnt    <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_err_geo     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start && !abort) begin
                r_mode     <= continuous;
                r_stop_req <= 1'b0;
            end else if (r_state != ST_IDLE && stop && !abort) begin
                r_stop_req <= 1'b1;
            end
            if (w_fwd) begin
                r_byte_cnt <= s_axis_tlast ? '0 : w_byte_inc;
                r_line_cnt <= s_axis_tlast ? w_line_inc : w_base_line;
            end
            if (w_frame_end) r_frame_count <= r_frame_count + CNT_W'(1);
            r_frame_done <= w_frame_end;
            r_err_ovf    <= (r_err_ovf && !clear_err) || w_ovf;
            r_err_geo    <= (r_err_geo && !clear_err) || w_geo;
        end
    end

    // Output stage: a beat transfers when m_axis_tvalid and m_axis_tready are both high on a
    // clock edge; once raised, tvalid and the payload stay stable until that transfer happens.
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
        end else if (w_fwd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= s_axis_tdata;
            r_out_last  <= s_axis_tlast;
            r_out_user  <= s_axis_tuser;
        end else if (m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;
    assign err_overflow  = r_err_ovf;
    assign err_geometry  = r_err_geo;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed and randomized bench for dvp_capture_ctrl with a 4x3 frame geometry.
// Expected output beats are queued by the scenario code from frame-level capture rules.
module tb_dvp_capture_ctrl;

    localparam int H = 4;
    localparam int V = 3;
    localparam int CW = 16;

    logic          pclk = 1'b0;
    logic          aresetn;
    logic [7:0]    s_tdata;
    logic          s_tvalid, s_tlast, s_tuser;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic          start, continuous, stop, abort, clear_err;
    logic          busy, frame_done, err_overflow, err_geometry;
    logic [CW-1:0] frame_count;

    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            exp_frames = 0;
    int            exp_done = 0;
    int            gap_max = 0;
    logic [9:0]    exp_q[$];

    dvp_capture_ctrl #(.H_BYTES(H), .V_LINES(V), .CNT_W(CW)) dut (
        .pclk(pclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .start(start), .continuous(continuous), .stop(stop), .abort(abort), .clear_err(clear_err),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .err_overflow(err_overflow), .err_geometry(err_geometry)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each accepted output beat must match the oldest expected beat.
    always @(negedge pclk) begin
        if (aresetn === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_beat observed=%0h expected=none", {m_tuser, m_tlast, m_tdata});
            end
            if (exp_q.size() != 0) check("out_beat", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
        end
        if (aresetn === 1'b1 && frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic beat(input logic u, input logic l, input bit fwd);
        logic [7:0] d;
        d = 8'($urandom);
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        if (fwd) exp_q.push_back({u, l, d});
        tick();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic line(input int n, input bit sof, input bit eol, input bit fwd);
        for (int i = 0; i < n; i++) beat(sof && i == 0, eol && i == n - 1, fwd);
    endtask

    task automatic frame(input bit fwd);
        line(H, 1'b1, 1'b1, fwd);
        line(H, 1'b0, 1'b1, fwd);
        line(H, 1'b0, 1'b1, fwd);
    endtask

    task automatic pulse_start(input logic cont);
        continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        repeat (4) tick();
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_frame_count"}, frame_count, exp_frames);
        check({tag, "_frame_done_cnt"}, done_cnt, exp_done);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; s_tdata = '0; s_tvalid = 0; s_tlast = 0; s_tuser = 0; m_tready = 1'b1;
        start = 0; continuous = 0; stop = 0; abort = 0; clear_err = 0;
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_frame_count", frame_count, 0);
        check("rst_errs", {err_overflow, err_geometry, frame_done}, 3'b000);
        aresetn = 1'b1;
        tick();

        // Single shot armed mid-frame: remainder of frame 1 dropped, frame 2 captured, frame 3 ignored.
        line(H, 1'b1, 1'b1, 1'b0);
        line(2, 1'b0, 1'b0, 1'b0);
        pulse_start(1'b0);
        check("s1_busy_armed", busy, 1'b1);
        line(2, 1'b0, 1'b1, 1'b0);
        line(H, 1'b0, 1'b1, 1'b0);
        frame(1'b1); exp_frames++; exp_done++;
        check("s1_busy_after", busy, 1'b0);
        frame(1'b0);
        drain_and_check("s1");
        check("s1_errs", {err_overflow, err_geometry}, 2'b00);

        // Continuous with stop during frame 2.
        pulse_start(1'b1);
        frame(1'b1);
        line(H, 1'b1, 1'b1, 1'b1);
        line(1, 1'b0, 1'b0, 1'b1);
        pulse_stop();
        line(3, 1'b0, 1'b1, 1'b1);
        line(3, 1'b0, 1'b0, 1'b1);
        check("s2_busy_before_end", busy, 1'b1);
        beat(1'b0, 1'b1, 1'b1);
        check("s2_busy_after_end", busy, 1'b0);
        exp_frames += 2; exp_done += 2;
        frame(1'b0);
        drain_and_check("s2");

        // Short line 2: geometry error at its tlast, frame still counts.
        pulse_start(1'b0);
        line(H, 1'b1, 1'b1, 1'b1);
        line(2, 1'b0, 1'b0, 1'b1);
        check("s3_geo_before", err_geometry, 1'b0);
        beat(1'b0, 1'b1, 1'b1);
        check("s3_geo_at_tlast", err_geometry, 1'b1);
        line(H, 1'b0, 1'b1, 1'b1);
        exp_frames++; exp_done++;
        drain_and_check("s3");
        pulse_clear();
        check("s3_geo_cleared", err_geometry, 1'b0);

        // Sink stall: first beat held, second dropped, resync on next SOF.
        pulse_start(1'b0);
        line(H, 1'b1, 1'b1, 1'b1);
        tick();
        m_tready = 1'b0;
        beat(1'b0, 1'b0, 1'b1);
        check("s4_ovf_before", err_overflow, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        check("s4_ovf_set", err_overflow, 1'b1);
        check("s4_held_valid", m_tvalid, 1'b1);
        check("s4_busy_waiting", busy, 1'b1);
        m_tready = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        line(H, 1'b0, 1'b1, 1'b0);
        frame(1'b1); exp_frames++; exp_done++;
        drain_and_check("s4");
        check("s4_ovf_sticky", err_overflow, 1'b1);
        pulse_clear();
        check("s4_ovf_cleared", err_overflow, 1'b0);

        // New SOF after 1.5 lines: no frame_done for the broken frame.
        pulse_start(1'b0);
        line(H, 1'b1, 1'b1, 1'b1);
        line(2, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        check("s5_geo_early_sof", err_geometry, 1'b1);
        check("s5_no_done", done_cnt, exp_done);
        line(H - 1, 1'b0, 1'b1, 1'b1);
        line(H, 1'b0, 1'b1, 1'b1);
        line(H, 1'b0, 1'b1, 1'b1);
        exp_frames++; exp_done++;
        drain_and_check("s5");
        pulse_clear();

        // Abort with a pending beat under tready=0 and a beat arriving in the abort cycle.
        pulse_start(1'b1);
        line(H, 1'b1, 1'b1, 1'b1);
        tick();
        m_tready = 1'b0;
        beat(1'b0, 1'b0, 1'b1);
        s_tdata = 8'($urandom); s_tvalid = 1'b1; abort = 1'b1;
        tick();
        s_tvalid = 1'b0; abort = 1'b0;
        check("s6_busy_abort", busy, 1'b0);
        check("s6_pending_valid", m_tvalid, 1'b1);
        check("s6_no_ovf", err_overflow, 1'b0);
        line(2, 1'b0, 1'b1, 1'b0);
        frame(1'b0);
        check("s6_still_pending", m_tvalid, 1'b1);
        m_tready = 1'b1;
        frame(1'b0);
        drain_and_check("s6");

        // start together with abort is ignored.
        continuous = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("s7_start_abort_busy", busy, 1'b0);
        frame(1'b0);
        drain_and_check("s7");

        // Randomized continuous run with idle gaps, stopped inside the last frame.
        begin
            int nf;
            nf = $urandom_range(2, 4);
            gap_max = 3;
            pulse_start(1'b1);
            for (int f = 0; f < nf - 1; f++) frame(1'b1);
            line(H, 1'b1, 1'b1, 1'b1);
            pulse_stop();
            line(H, 1'b0, 1'b1, 1'b1);
            line(H, 1'b0, 1'b1, 1'b1);
            exp_frames += nf; exp_done += nf;
            frame(1'b0);
            gap_max = 0;
            drain_and_check("s8");
        end

        // Asynchronous reset mid-frame with a beat sitting in the output register.
        pulse_start(1'b0);
        beat(1'b1, 1'b1, 1'b1);
        check("s9_geo_single_byte_line", err_geometry, 1'b1);
        tick();
        beat(1'b0, 1'b0, 1'b0);
        #1 aresetn = 1'b0;
        #1;
        check("s9_rst_tvalid", m_tvalid, 1'b0);
        check("s9_rst_busy", busy, 1'b0);
        check("s9_rst_count", frame_count, 0);
        check("s9_rst_errs", {err_overflow, err_geometry, frame_done}, 3'b000);
        tick();
        aresetn = 1'b1;
        exp_frames = 0;
        tick();
        frame(1'b0);
        check("s9_no_capture_without_start", busy, 1'b0);
        pulse_start(1'b0);
        frame(1'b1); exp_frames++; exp_done++;
        drain_and_check("s9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
